prog_loader: RTL and testbench

Byte-stream program loader for the MIPS single-cycle datapath. It receives a framed byte stream and assembles big-endian 32-bit words. Each word is written into either the instruction memory or the register bank. The CPU is held in reset until a load completes. This replaces file-based preloading of memories and lets the same bench and the FPGA build load programs through one port.

---
 rtl/loader_pkg.sv | 16 +
 rtl/prog_loader.sv | 202 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream program loader: command codes and FSM states.
package loader_pkg;

   localparam logic [7:0] CMD_IM = 8'h01;
   localparam logic [7:0] CMD_RB = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_COUNT,
      S_DATA,
      S_WRITE,
      S_FIN
   } state_t;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles big-endian words and writes them into the
// instruction memory or the register bank while holding the CPU in reset.
module prog_loader
   import loader_pkg::*;
#(
   parameter int IM_AW = 8,
   parameter int RB_AW = 5
) (
   input  logic             clk_CPU,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             im_we,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      im_wdata,
   output logic             rb_we,
   output logic [RB_AW-1:0] rb_addr,
   output logic [31:0]      rb_wdata,
   output logic             cpu_rst,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // One address counter serves both targets; it is masked to the selected width.
   localparam int CW = (IM_AW > RB_AW) ? IM_AW : RB_AW;
   localparam logic [CW-1:0] IM_MASK = CW'((64'd1 << IM_AW) - 64'd1);
   localparam logic [CW-1:0] RB_MASK = CW'((64'd1 << RB_AW) - 64'd1);

   state_t           state_reg, state_next;
   logic             sel_rb_reg, sel_rb_next;
   logic [CW-1:0]    addr_reg, addr_next;
   logic [8:0]       cnt_reg, cnt_next;
   logic [23:0]      word_reg, word_next;
   logic [1:0]       byte_cnt_reg, byte_cnt_next;
   logic             rx_ready_reg, rx_ready_next;
   logic             im_we_reg, im_we_next;
   logic [IM_AW-1:0] im_addr_reg, im_addr_next;
   logic [31:0]      im_wdata_reg, im_wdata_next;
   logic             rb_we_reg, rb_we_next;
   logic [RB_AW-1:0] rb_addr_reg, rb_addr_next;
   logic [31:0]      rb_wdata_reg, rb_wdata_next;
   logic             cpu_rst_reg, cpu_rst_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             err_reg, err_next;

   logic             accept;
   logic [CW-1:0]    addr_mask;
   logic [8:0]       cnt_dec;
   logic [31:0]      full_word;

   assign accept    = rx_valid && rx_ready_reg;
   assign addr_mask = sel_rb_reg ? RB_MASK : IM_MASK;
   assign cnt_dec   = cnt_reg - 9'd1;
   assign full_word = {word_reg, rx_data};

   always_comb begin
      state_next    = state_reg;
      sel_rb_next   = sel_rb_reg;
      addr_next     = addr_reg;
      cnt_next      = cnt_reg;
      word_next     = word_reg;
      byte_cnt_next = byte_cnt_reg;
      im_we_next    = 1'b0;
      im_addr_next  = im_addr_reg;
      im_wdata_next = im_wdata_reg;
      rb_we_next    = 1'b0;
      rb_addr_next  = rb_addr_reg;
      rb_wdata_next = rb_wdata_reg;
      cpu_rst_next  = cpu_rst_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      err_next      = err_reg;

      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               if (rx_data == CMD_IM || rx_data == CMD_RB) begin
                  sel_rb_next  = (rx_data == CMD_RB);
                  err_next     = 1'b0;
                  busy_next    = 1'b1;
                  cpu_rst_next = 1'b1;
                  state_next   = S_ADDR;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (accept) begin
               addr_next  = CW'(rx_data) & addr_mask;
               state_next = S_COUNT;
            end
         end
         S_COUNT: begin
            if (accept) begin
               cnt_next      = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
               byte_cnt_next = 2'd0;
               state_next    = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               word_next     = full_word[23:0];
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  state_next = S_WRITE;
                  if (sel_rb_reg) begin
                     rb_we_next    = 1'b1;
                     rb_addr_next  = addr_reg[RB_AW-1:0];
                     rb_wdata_next = full_word;
                  end else begin
                     im_we_next    = 1'b1;
                     im_addr_next  = addr_reg[IM_AW-1:0];
                     im_wdata_next = full_word;
                  end
               end
            end
         end
         S_WRITE: begin
            addr_next = (addr_reg + CW'(1)) & addr_mask;
            cnt_next  = cnt_dec;
            // Stepping past the top only counts as a wrap if another word follows.
            if (addr_reg == addr_mask && cnt_dec != 9'd0) begin
               err_next = 1'b1;
            end
            if (cnt_dec == 9'd0) begin
               done_next    = 1'b1;
               busy_next    = 1'b0;
               cpu_rst_next = 1'b0;
               state_next   = S_FIN;
            end else begin
               state_next = S_DATA;
            end
         end
         S_FIN: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      rx_ready_next = (state_next == S_IDLE) || (state_next == S_ADDR) ||
                      (state_next == S_COUNT) || (state_next == S_DATA);
   end

   always_ff @(posedge clk_CPU) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         sel_rb_reg   <= 1'b0;
         addr_reg     <= '0;
         cnt_reg      <= '0;
         word_reg     <= '0;
         byte_cnt_reg <= '0;
         rx_ready_reg <= 1'b0;
         im_we_reg    <= 1'b0;
         im_addr_reg  <= '0;
         im_wdata_reg <= '0;
         rb_we_reg    <= 1'b0;
         rb_addr_reg  <= '0;
         rb_wdata_reg <= '0;
         cpu_rst_reg  <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         sel_rb_reg   <= sel_rb_next;
         addr_reg     <= addr_next;
         cnt_reg      <= cnt_next;
         word_reg     <= word_next;
         byte_cnt_reg <= byte_cnt_next;
         rx_ready_reg <= rx_ready_next;
         im_we_reg    <= im_we_next;
         im_addr_reg  <= im_addr_next;
         im_wdata_reg <= im_wdata_next;
         rb_we_reg    <= rb_we_next;
         rb_addr_reg  <= rb_addr_next;
         rb_wdata_reg <= rb_wdata_next;
         cpu_rst_reg  <= cpu_rst_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   assign rx_ready = rx_ready_reg;
   assign im_we    = im_we_reg;
   assign im_addr  = im_addr_reg;
   assign im_wdata = im_wdata_reg;
   assign rb_we    = rb_we_reg;
   assign rb_addr  = rb_addr_reg;
   assign rb_wdata = rb_wdata_reg;
   assign cpu_rst  = cpu_rst_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames push expected writes/done events,
// a negedge monitor pops and compares whatever the loader emits.
module tb_prog_loader;

   logic        clk_CPU = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        im_we;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;
   logic        rb_we;
   logic [4:0]  rb_addr;
   logic [31:0] rb_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int          kind;   // 0 = IM write, 1 = RB write, 2 = done {err,cpu_rst,busy}
      int          addr;
      logic [31:0] data;
   } ev_t;

   ev_t exp_q[$];

   prog_loader #(.IM_AW(8), .RB_AW(5)) dut (
      .clk_CPU  (clk_CPU),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .rb_we    (rb_we),
      .rb_addr  (rb_addr),
      .rb_wdata (rb_wdata),
      .cpu_rst  (cpu_rst),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk_CPU = ~clk_CPU;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_w(input int kind, input int addr, input logic [31:0] data);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input logic err_exp);
      push_w(2, 0, {29'd0, err_exp, 1'b0, 1'b0});
   endtask

   task automatic compare_pop(input ev_t got);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event kind=%0d addr=%0d data=%h required=none",
                  got.kind, got.addr, got.data);
      end else begin
         e = exp_q.pop_front();
         $display("txn kind=%0d addr=%0d data=%h", got.kind, got.addr, got.data);
         if (got.kind != e.kind || got.addr != e.addr || got.data !== e.data) begin
            failures++;
            $display("FAIL event actual=(%0d,%0d,%h) required=(%0d,%0d,%h)",
                     got.kind, got.addr, got.data, e.kind, e.addr, e.data);
         end
      end
   endtask

   // Returns at posedge+1 after the accepting edge; rx_valid stays low only mid-cycle.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk_CPU);
      while (!rx_ready && n < 200) begin
         @(negedge clk_CPU);
         n++;
      end
      if (!rx_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout byte=%h actual=ready_low required=ready_high", b);
      end
      @(posedge clk_CPU);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[31:24]);
      send(w[23:16]);
      send(w[15:8]);
      send(w[7:0]);
   endtask

   task automatic check_reset_outputs();
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_im_we",    {31'd0, im_we},    32'd0);
      chk("rst_rb_we",    {31'd0, rb_we},    32'd0);
      chk("rst_im_addr",  {24'd0, im_addr},  32'd0);
      chk("rst_rb_addr",  {27'd0, rb_addr},  32'd0);
      chk("rst_im_wdata", im_wdata,          32'd0);
      chk("rst_rb_wdata", rb_wdata,          32'd0);
      chk("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_done",     {31'd0, done},     32'd0);
      chk("rst_err",      {31'd0, err},      32'd0);
   endtask

   // Monitor: strobes and done are consumed against the scoreboard.
   always @(negedge clk_CPU) begin
      ev_t got;
      if (!rst) begin
         if (im_we || rb_we || done) begin
            chk("ready_low_in_write_fin", {31'd0, rx_ready}, 32'd0);
         end
         if (im_we && rb_we) begin
            chk("both_strobes", 32'd1, 32'd0 + {31'd0, ~(im_we & rb_we)});
         end
         if (im_we) begin
            got.kind = 0; got.addr = int'(im_addr); got.data = im_wdata;
            compare_pop(got);
         end
         if (rb_we) begin
            got.kind = 1; got.addr = int'(rb_addr); got.data = rb_wdata;
            compare_pop(got);
         end
         if (done) begin
            got.kind = 2; got.addr = 0; got.data = {29'd0, err, cpu_rst, busy};
            compare_pop(got);
         end
      end
   end

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk_CPU);
      @(negedge clk_CPU);
      check_reset_outputs();
      rst = 1'b0;
      @(posedge clk_CPU);
      #1;

      // IM load, two words
      push_w(0, 0, 32'h20080005);
      push_w(0, 1, 32'h012A4020);
      push_done(1'b0);
      send(8'h01); send(8'h00); send(8'h02);
      send_word(32'h20080005);
      send_word(32'h012A4020);
      repeat (3) @(posedge clk_CPU);
      #1;
      chk("im_load_cpu_rst", {31'd0, cpu_rst}, 32'd0);

      // Bad command then a valid one that clears err
      send(8'h07);
      chk("bad_cmd_err",     {31'd0, err},      32'd1);
      chk("bad_cmd_cpu_rst", {31'd0, cpu_rst},  32'd0);
      chk("bad_cmd_busy",    {31'd0, busy},     32'd0);
      chk("bad_cmd_ready",   {31'd0, rx_ready}, 32'd1);
      push_w(0, 16, 32'hDEADBEEF);
      push_done(1'b0);
      send(8'h01);
      chk("good_cmd_err",     {31'd0, err},     32'd0);
      chk("good_cmd_busy",    {31'd0, busy},    32'd1);
      chk("good_cmd_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      send(8'h10); send(8'h01);
      send(8'hDE); send(8'hAD);
      // Gap of 10 cycles mid-word: loader waits with ready high, no strobes
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_CPU);
         chk("gap_ready", {31'd0, rx_ready}, 32'd1);
         chk("gap_no_strobe", {30'd0, im_we, rb_we}, 32'd0);
      end
      @(posedge clk_CPU);
      #1;
      send(8'hBE); send(8'hEF);

      // RB load that wraps 31 -> 0
      push_w(1, 31, 32'h11223344);
      push_w(1, 0,  32'h55667788);
      push_done(1'b1);
      send(8'h02); send(8'h1F); send(8'h02);
      send_word(32'h11223344);
      send_word(32'h55667788);
      repeat (3) @(posedge clk_CPU);
      #1;
      chk("wrap_err_sticky", {31'd0, err}, 32'd1);

      // Reset mid-frame after two data bytes
      send(8'h01); send(8'h20); send(8'h01);
      send(8'hAA); send(8'hBB);
      rst = 1'b1;
      @(posedge clk_CPU);
      #1;
      check_reset_outputs();
      rst = 1'b0;
      push_w(1, 5, 32'hCAFEF00D);
      push_done(1'b0);
      send(8'h02); send(8'h05); send(8'h01);
      send_word(32'hCAFEF00D);

      // CNT = 0 means 256 words
      for (int i = 0; i < 256; i++) push_w(0, i, 32'hA5000000 | i);
      push_done(1'b0);
      send(8'h01); send(8'h00); send(8'h00);
      for (int i = 0; i < 256; i++) send_word(32'hA5000000 | i);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk_CPU);
         n++;
      end
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      chk("final_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("final_busy", {31'd0, busy}, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
